// File: rtl/c1_pkg.sv
// Shared constants, lane indices, state encoding and signed-max helpers for the C1 pooling stage.
package c1_pkg;

    localparam int DATA_W = 8;
    localparam int N_CH   = 6;
    localparam int S1_W   = 14;
    localparam int S1_H   = 14;
    localparam int BLK_W  = 4 * DATA_W;
    localparam int CNT_W  = 4;

    // Byte lanes of a packed 2x2 block: {TL, TR, BL, BR}, TL in the top byte.
    localparam int LANE_TL = 3;
    localparam int LANE_TR = 2;
    localparam int LANE_BL = 1;
    localparam int LANE_BR = 0;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] lane(input logic [BLK_W-1:0] blk,
                                               input int                idx);
        return blk[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/c1_max4_pipe.sv
// One channel's two-stage signed max of a 2x2 block.
// Define C1_MAXPOOL_RELU_EN to clamp negative results to zero at stage 2.
module c1_max4_pipe
    import c1_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en1,
    input  logic              en2,
    input  logic [BLK_W-1:0]  blk,
    output logic [DATA_W-1:0] pix
);

    logic [DATA_W-1:0] top_q, top_d;
    logic [DATA_W-1:0] bot_q, bot_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [DATA_W-1:0] max_w;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        top_d = top_q;
        bot_d = bot_q;
        pix_d = pix_q;
        if (en1) begin
            top_d = smax(lane(blk, LANE_TL), lane(blk, LANE_TR));
            bot_d = smax(lane(blk, LANE_BL), lane(blk, LANE_BR));
        end
        max_w = smax(top_q, bot_q);
`ifdef C1_MAXPOOL_RELU_EN
        if (max_w[DATA_W-1]) begin
            max_w = '0;
        end
`endif
        // Output register only loads on a launch so the pixel holds between beats.
        if (en2) begin
            pix_d = max_w;
        end
    end

    // NOTE: data registers take the async reset too; they are small flops, not a RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state is assigned with <= so all flops update together.
            top_q <= '0;
            bot_q <= '0;
            pix_q <= '0;
        end else begin
            top_q <= top_d;
            bot_q <= bot_d;
            pix_q <= pix_d;
        end
    end

    assign pix = pix_q;

endmodule

// File: rtl/c1_maxpool_2x2.sv
// 2x2 max-pool of six C1 channels onto the 14x14 S1 map, with coordinate and frame tracking.
// Optional ReLU fusion is selected with C1_MAXPOOL_RELU_EN (see c1_max4_pipe).
module c1_maxpool_2x2
    import c1_pkg::*;
#(
    parameter int OUT_W = S1_W,
    parameter int OUT_H = S1_H
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              soft_clr,
    input  logic              pool_valid,
    input  logic [BLK_W-1:0]  pool_ch0,
    input  logic [BLK_W-1:0]  pool_ch1,
    input  logic [BLK_W-1:0]  pool_ch2,
    input  logic [BLK_W-1:0]  pool_ch3,
    input  logic [BLK_W-1:0]  pool_ch4,
    input  logic [BLK_W-1:0]  pool_ch5,
    output logic              s1_valid,
    output logic [DATA_W-1:0] s1_ch0,
    output logic [DATA_W-1:0] s1_ch1,
    output logic [DATA_W-1:0] s1_ch2,
    output logic [DATA_W-1:0] s1_ch3,
    output logic [DATA_W-1:0] s1_ch4,
    output logic [DATA_W-1:0] s1_ch5,
    output logic [CNT_W-1:0]  s1_col,
    output logic [CNT_W-1:0]  s1_row,
    output logic              s1_frame_done,
    output logic              s1_err
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_H - 1);

    logic [BLK_W-1:0]  blk [N_CH];
    logic [DATA_W-1:0] pix [N_CH];
    logic              accept;
    logic              launch;

    logic             v1_q, v1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] s1_col_q, s1_col_d;
    logic [CNT_W-1:0] s1_row_q, s1_row_d;

    assign blk[0] = pool_ch0;
    assign blk[1] = pool_ch1;
    assign blk[2] = pool_ch2;
    assign blk[3] = pool_ch3;
    assign blk[4] = pool_ch4;
    assign blk[5] = pool_ch5;

    // soft_clr wins over both pipeline stages: an accepting beat is dropped, a launch is squashed.
    assign accept = pool_valid & ~soft_clr;
    assign launch = v1_q & ~soft_clr;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        c1_max4_pipe u_pipe (
            .clk     (clk),
            .reset_n (reset_n),
            .en1     (accept),
            .en2     (launch),
            .blk     (blk[g]),
            .pix     (pix[g])
        );
    end

    always_comb begin
        v1_d       = accept;
        s1_valid_d = launch;
        done_d     = 1'b0;
        err_d      = err_q;
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        s1_col_d   = s1_col_q;
        s1_row_d   = s1_row_q;
        if (soft_clr) begin
            col_d   = '0;
            row_d   = '0;
            state_d = ST_IDLE;
            if (state_q == ST_ACTIVE) begin
                err_d = 1'b1;
            end
        end else if (v1_q) begin
            s1_col_d = col_q;
            s1_row_d = row_q;
            state_d  = ST_ACTIVE;
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q       <= 1'b0;
            s1_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
        end else begin
            v1_q       <= v1_d;
            s1_valid_q <= s1_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
        end
    end

    assign s1_valid      = s1_valid_q;
    assign s1_frame_done = done_q;
    assign s1_err        = err_q;
    assign s1_col        = s1_col_q;
    assign s1_row        = s1_row_q;
    assign s1_ch0        = pix[0];
    assign s1_ch1        = pix[1];
    assign s1_ch2        = pix[2];
    assign s1_ch3        = pix[3];
    assign s1_ch4        = pix[4];
    assign s1_ch5        = pix[5];

endmodule

// File: tb/tb_c1_maxpool_2x2.sv
// Self-checking bench for c1_maxpool_2x2: random and directed 2x2 blocks against a scoreboard model.
`timescale 1ns/1ps
module tb_c1_maxpool_2x2;

    localparam int NCH   = 6;
    localparam int MAP_W = 14;
    localparam int FRAME = 196;

    typedef struct packed {
        int                      due;
        logic [NCH-1:0][31:0]    blk;
    } beat_t;

    logic        clk = 1'b0;
    bit          clk_run = 1'b1;
    logic        reset_n;
    logic        soft_clr;
    logic        pool_valid;
    logic [31:0] pool_ch [NCH];
    logic [7:0]  s1_ch [NCH];
    logic        s1_valid;
    logic [3:0]  s1_col;
    logic [3:0]  s1_row;
    logic        s1_frame_done;
    logic        s1_err;

    c1_maxpool_2x2 dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .soft_clr      (soft_clr),
        .pool_valid    (pool_valid),
        .pool_ch0      (pool_ch[0]),
        .pool_ch1      (pool_ch[1]),
        .pool_ch2      (pool_ch[2]),
        .pool_ch3      (pool_ch[3]),
        .pool_ch4      (pool_ch[4]),
        .pool_ch5      (pool_ch[5]),
        .s1_valid      (s1_valid),
        .s1_ch0        (s1_ch[0]),
        .s1_ch1        (s1_ch[1]),
        .s1_ch2        (s1_ch[2]),
        .s1_ch3        (s1_ch[3]),
        .s1_ch4        (s1_ch[4]),
        .s1_ch5        (s1_ch[5]),
        .s1_col        (s1_col),
        .s1_row        (s1_row),
        .s1_frame_done (s1_frame_done),
        .s1_err        (s1_err)
    );

    // Clock parks low when clk_run drops.
    initial begin
        forever begin
            #5;
            if (clk_run || clk) clk = ~clk;
        end
    end

    int                   checks = 0;
    int                   failures = 0;
    int                   cyc = 0;
    int                   out_idx = 0;
    int                   valid_seen = 0;
    int                   done_seen = 0;
    beat_t                pend [$];
    logic [NCH-1:0][31:0] blk_next;
    logic [7:0]           last_ch [NCH];
    logic [3:0]           last_col;
    logic [3:0]           last_row;
    bit                   data_known;
    logic                 exp_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Largest of the four signed pixels; clamped at zero when ReLU is fused.
    function automatic logic [7:0] ref_pool(input logic [31:0] b);
        int         m;
        int         v;
        logic [7:0] px;
        m = -128;
        for (int i = 0; i < 4; i++) begin
            px = b[8*i +: 8];
            v  = $signed(px);
            if (v > m) m = v;
        end
`ifdef C1_MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m[7:0];
    endfunction

    task automatic model_reset();
        pend.delete();
        out_idx    = 0;
        last_col   = '0;
        last_row   = '0;
        data_known = 1'b1;
        exp_err    = 1'b0;
        for (int c = 0; c < NCH; c++) last_ch[c] = '0;
    endtask

    task automatic randomize_next();
        for (int c = 0; c < NCH; c++) blk_next[c] = $urandom();
    endtask

    task automatic compare();
        bit    exp_v;
        beat_t e;
        int    idx;
        exp_v = (pend.size() != 0) && (pend[0].due == cyc);
        check("s1_valid", {31'd0, s1_valid}, {31'd0, exp_v});
        if (s1_valid === 1'b1) valid_seen++;
        if (s1_frame_done === 1'b1) done_seen++;
        if (exp_v) begin
            e   = pend.pop_front();
            idx = out_idx;
            for (int c = 0; c < NCH; c++) last_ch[c] = ref_pool(e.blk[c]);
            last_col   = 4'(idx % MAP_W);
            last_row   = 4'(idx / MAP_W);
            data_known = 1'b1;
            check("s1_frame_done", {31'd0, s1_frame_done}, {31'd0, idx == FRAME - 1});
            out_idx = (idx == FRAME - 1) ? 0 : idx + 1;
        end else begin
            check("s1_frame_done_idle", {31'd0, s1_frame_done}, 32'd0);
        end
        if (data_known) begin
            for (int c = 0; c < NCH; c++) check($sformatf("s1_ch%0d", c), {24'd0, s1_ch[c]}, {24'd0, last_ch[c]});
        end
        check("s1_col", {28'd0, s1_col}, {28'd0, last_col});
        check("s1_row", {28'd0, s1_row}, {28'd0, last_row});
        check("s1_err", {31'd0, s1_err}, {31'd0, exp_err});
    endtask

    // One clock: check what the last edge produced, then drive the next inputs.
    task automatic step(input logic v, input logic clr);
        beat_t e;
        @(posedge clk);
        #1;
        cyc++;
        compare();
        pool_valid = v;
        soft_clr   = clr;
        for (int c = 0; c < NCH; c++) pool_ch[c] = blk_next[c];
        if (clr) begin
            // A frame is in progress iff some output of it has already appeared.
            if (out_idx != 0) exp_err = 1'b1;
            pend.delete();
            out_idx    = 0;
            data_known = 1'b0;
        end else if (v) begin
            e.due = cyc + 2;
            e.blk = blk_next;
            pend.push_back(e);
        end
        randomize_next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        soft_clr   = 1'b0;
        pool_valid = 1'b0;
        for (int c = 0; c < NCH; c++) pool_ch[c] = '0;
        model_reset();
        randomize_next();
        #12;
        compare();
        #11;
        reset_n = 1'b1;
        repeat (2) step(1'b0, 1'b0);

        // Full frame, first block directed: ch0 -> 7F, ch1 -> FF (00 with ReLU).
        blk_next[0] = 32'h057F_8010;
        blk_next[1] = 32'hF0F8_81FF;
        valid_seen  = 0;
        done_seen   = 0;
        repeat (FRAME) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        check("frame_valid_cnt", valid_seen, FRAME);
        check("frame_done_cnt", done_seen, 1);

        // Next frame starts at col 0, row 0; then gapped 1,0,1,1 traffic.
        step(1'b1, 1'b0);
        repeat (6) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
        end
        repeat (300) step(1'($urandom_range(0, 1)), 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Asynchronous reset mid-frame with the clock parked.
        pool_valid = 1'b0;
        clk_run    = 1'b0;
        #20;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare();
        #5;
        reset_n = 1'b1;
        #2;
        clk_run = 1'b1;

        // 30 beats, soft_clr with a coinciding beat, then a clean frame.
        repeat (30) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        valid_seen = 0;
        done_seen  = 0;
        repeat (FRAME) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        check("clr_frame_valid_cnt", valid_seen, FRAME);
        check("clr_frame_done_cnt", done_seen, 1);
        check("s1_err_sticky", {31'd0, s1_err}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c1_maxpool_2x2.md
Name: c1_maxpool_2x2

Overview:
- Downstream neighbour of the C1 register controller in the LeNet front end.
- Consumes 2x2 pixel blocks for 6 channels, one block per channel per valid beat, and emits one 2x2 max-pooled pixel per channel.
- Tracks output coordinates across the 14x14 S1 feature map and flags the last pixel of each frame for the C2 stage.
- No backpressure: upstream is valid-only, so this block accepts every beat.

Parameters:
- DATA_W, 8, pixel width; signed two's complement.
- N_CH, 6, channel count; fixed by the port list.
- OUT_W, 14, pooled map width (columns).
- OUT_H, 14, pooled map height (rows).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- soft_clr  in  1  synchronous clear of pipeline and counters
- pool_valid  in  1  input 2x2 blocks valid this cycle
- pool_ch0..pool_ch5  in  32 each  packed block {TL[31:24], TR[23:16], BL[15:8], BR[7:0]}
- s1_valid  out  1  pooled outputs valid
- s1_ch0..s1_ch5  out  8 each  pooled pixel per channel
- s1_col  out  4  column of current output, 0..13
- s1_row  out  4  row of current output, 0..13
- s1_frame_done  out  1  high with the output at row 13, col 13
- s1_err  out  1  sticky: soft_clr asserted mid-frame

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n). On reset all outputs, pipeline valids, data registers and counters go to 0.
- Pipeline stage 1, registered, per channel: top = smax(TL,TR), bot = smax(BL,BR); v1 <= pool_valid.
- Pipeline stage 2, registered, per channel: s1_chN = smax(top,bot); s1_valid <= v1.
- smax is a signed compare. Ties return the common value. No width growth; the result is DATA_W.
- Latency: exactly 2 cycles from pool_valid to s1_valid. Back-to-back beats give back-to-back outputs; gaps are preserved.
- s1_chN, s1_col and s1_row hold their last value while s1_valid=0.
- Counter state machine, two states:
  - IDLE: no output yet in this frame.
  - ACTIVE: frame in progress.
- Counter transitions:
  - On each stage-2 launch (v1=1), col_cnt/row_cnt are presented as s1_col/s1_row.
  - col_cnt then increments; at 13 it wraps to 0 and row_cnt increments.
  - At row 13, col 13: s1_frame_done=1 for that single cycle, both counters wrap to 0, state returns to IDLE.
  - The first launch moves IDLE to ACTIVE.
  - s1_frame_done is never high without s1_valid.
- soft_clr (highest priority after reset):
  - Clears v1, s1_valid, s1_frame_done and both counters the next cycle; state goes to IDLE.
  - A pool_valid coinciding with soft_clr is dropped.
  - Data registers are don't-care after soft_clr.
- s1_err: set when soft_clr arrives while state=ACTIVE; cleared only by reset_n.
- Frame boundary: a new frame may start the cycle after frame_done with no bubble; counting continues seamlessly.
- Async reset mid-frame: everything returns to 0 / IDLE immediately; beats in flight are lost.

Optional Feature:
- Macro: C1_MAXPOOL_RELU_EN.
- Defined: stage 2 output is clamped, s1_chN = (max < 0) ? 0 : max. This fuses ReLU; latency is unchanged.
- Undefined: the raw signed max passes through.

Decomposition:
- Shared package (c1_pkg) holds:
  - constants DATA_W=8, N_CH=6, S1_W=14, S1_H=14
  - byte-lane index constants for TL/TR/BL/BR
  - state encoding IDLE=1'b0, ACTIVE=1'b1
- Sub-module c1_max4_pipe: one channel's 2-stage signed max4 with optional ReLU. Instantiated N_CH times.
- The top level owns the valid pipeline, counters, FSM and s1_err.

Test Plan:
- Single beat, pool_ch0=32'h05_7F_80_10 → 2 cycles later: s1_valid=1, s1_ch0=8'h7F, s1_col=0, s1_row=0.
- Negative block, pool_ch1=32'hF0_F8_81_FF → s1_ch1=8'hFF without macro; 8'h00 with C1_MAXPOOL_RELU_EN.
- 196 contiguous beats:
  - exactly 196 s1_valid cycles;
  - s1_col/s1_row sweep 0..13 row-major;
  - s1_frame_done only on beat 196 (row 13, col 13);
  - the next beat gives col=0, row=0.
- Gapped input with pool_valid toggling 1,0,1,1 → s1_valid pattern identical, delayed by 2; counters advance only on valid outputs.
- soft_clr after 30 beats, then 196 beats → s1_err=1; the new frame starts at col 0, row 0 and frame_done lands on its 196th output.
- reset_n pulsed low asynchronously mid-frame with the clock stopped → all outputs 0 immediately; after release the first output is at col 0, row 0.
